// File: rtl/piso_ctrl_pkg.sv
// Shared types and constants for the nibble serializer and its arbiter.
package piso_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   localparam int unsigned DATA_BITS = 4;
   localparam logic        START_LVL = 1'b0;
   localparam logic        STOP_LVL  = 1'b1;

endpackage

// File: rtl/piso_tx_arbiter_if.sv
// Requester handshakes plus serial-line status for piso_tx_arbiter.
interface piso_tx_arbiter_if;
   import piso_ctrl_pkg::*;

   logic                 req0_valid;
   logic [DATA_BITS-1:0] req0_data;
   logic                 req0_ready;
   logic                 req1_valid;
   logic [DATA_BITS-1:0] req1_data;
   logic                 req1_ready;
   logic                 ser_out;
   logic                 busy;
   logic                 frame_src;
   logic                 frame_done;

   // Requester / observer side.
   modport master (
      output req0_valid, req0_data, req1_valid, req1_data,
      input  req0_ready, req1_ready, ser_out, busy, frame_src, frame_done
   );

   // Serializer side.
   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data,
      output req0_ready, req1_ready, ser_out, busy, frame_src, frame_done
   );

endinterface

// File: rtl/piso_shift4.sv
// Nibble shift register: parallel load, shift left towards the MSB tap.
module piso_shift4
   import piso_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 shift_en,
   input  logic [DATA_BITS-1:0] data_in,
   output logic                 msb_out
);

   logic [DATA_BITS-1:0] sr_q;

   // Load has priority over shift; zeros fill from the LSB.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else if (load) begin
         sr_q <= data_in;
      end else if (shift_en) begin
         sr_q <= {sr_q[DATA_BITS-2:0], 1'b0};
      end
   end

   assign msb_out = sr_q[DATA_BITS-1];

endmodule

// File: rtl/piso_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a nibble serializer.
// Frame: start bit, 4 data bits MSB first, stop bit; each bit DIV cycles.
module piso_tx_arbiter
   import piso_ctrl_pkg::*;
#(
   parameter int unsigned DIV = 1
) (
   input logic               clk,
   input logic               rst_n,
   piso_tx_arbiter_if.slave  bus
);

   localparam logic [7:0] DIV_M1  = 8'(DIV - 1);
   localparam logic [1:0] LAST_BIT = 2'(DATA_BITS - 1);

   state_e     state_q, state_d;
   logic [7:0] div_q, div_d;
   logic [1:0] bit_q, bit_d;
   logic       ser_q, ser_d;
   logic       busy_q;
   logic       done_q, done_d;
   logic       src_q, src_d;
   logic       ptr_q, ptr_d;
   logic       ready0, ready1, fire, win1;
   logic       bit_end, load, shift_en, msb;

   // Round-robin grant; ready only in IDLE and out of reset.
   always_comb begin
      ready0 = rst_n && (state_q == IDLE) && bus.req0_valid &&
               (!bus.req1_valid || !ptr_q);
      ready1 = rst_n && (state_q == IDLE) && bus.req1_valid &&
               (!bus.req0_valid || ptr_q);
      fire   = ready0 || ready1;
      win1   = ready1;
   end

   assign bit_end = (div_q == DIV_M1);

   // Next-state for FSM, counters, line level and shifter controls.
   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      bit_d    = bit_q;
      ser_d    = ser_q;
      src_d    = src_q;
      ptr_d    = ptr_q;
      load     = 1'b0;
      shift_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (fire) begin
               state_d = START;
               div_d   = '0;
               ser_d   = START_LVL;
               load    = 1'b1;
               src_d   = win1;
               ptr_d   = ~win1;
            end
         end
         default: begin
            if (!bit_end) begin
               div_d = div_q + 8'd1;
            end else begin
               div_d = '0;
               case (state_q)
                  START: begin
                     state_d  = DATA;
                     bit_d    = '0;
                     ser_d    = msb;
                     shift_en = 1'b1;
                  end
                  DATA: begin
                     if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                        bit_d   = '0;
                        ser_d   = STOP_LVL;
                     end else begin
                        bit_d    = bit_q + 2'd1;
                        ser_d    = msb;
                        shift_en = 1'b1;
                     end
                  end
                  default: begin
                     state_d = IDLE;
                     ser_d   = STOP_LVL;
                  end
               endcase
            end
         end
      endcase
      // Pulse lands on the final STOP cycle, whatever DIV is.
      done_d = (state_d == STOP) && (div_d == DIV_M1);
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         ser_q   <= STOP_LVL;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         src_q   <= 1'b0;
         ptr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         ser_q   <= ser_d;
         busy_q  <= (state_d != IDLE);
         done_q  <= done_d;
         src_q   <= src_d;
         ptr_q   <= ptr_d;
      end
   end

   piso_shift4 u_shift (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .shift_en (shift_en),
      .data_in  (win1 ? bus.req1_data : bus.req0_data),
      .msb_out  (msb)
   );

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.ser_out    = ser_q;
   assign bus.busy       = busy_q;
   assign bus.frame_src  = src_q;
   assign bus.frame_done = done_q;

endmodule
